// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control unit: opcode/funct constants,
// FSM state and ALU control encodings, and the instruction classifier.
package ctrl_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT
  } state_t;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_CMP = 1'b1
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    INS_ADDI,
    INS_ADD,
    INS_BEQ,
    INS_BNE,
    INS_ILL
  } ins_t;

  function automatic ins_t classify(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7);
    ins_t c;
    c = INS_ILL;
    if (op == OP_IMM && f3 == F3_ADD)                      c = INS_ADDI;
    else if (op == OP_REG && f3 == F3_ADD && f7 == F7_ADD) c = INS_ADD;
    else if (op == OP_BRANCH && f3 == F3_BEQ)              c = INS_BEQ;
    else if (op == OP_BRANCH && f3 == F3_BNE)              c = INS_BNE;
    return c;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction: sign-extended I-type and B-type immediates.
module imm_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr,
  output logic [DATA_WIDTH-1:0] imm_i,
  output logic [DATA_WIDTH-1:0] imm_b
);

  logic unused_bits;
  assign unused_bits = ^{instr[19:12], instr[6:0]};

  assign imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_b = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                  instr[11:8], 1'b0};

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM (fetch/decode/execute/writeback) with registered outputs.
// Optional retire counter output enabled by defining CPU_CTRL_RETIRE_CNT_EN.
module cpu_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  instr_req,
  output logic [DATA_WIDTH-1:0] pc,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  input  logic                  EQ,
  output logic                  ALUctrl,
  output logic                  ALUsrc,
  output logic [DATA_WIDTH-1:0] ImmOp,
  output logic [ADDR_WIDTH-1:0] rs1,
  output logic [ADDR_WIDTH-1:0] rs2,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic                  RegWrite,
  output logic                  halted
`ifdef CPU_CTRL_RETIRE_CNT_EN
  ,
  output logic [DATA_WIDTH-1:0] retired
`endif
);

  state_t state, next_state;
  ins_t   ins_q, ins_in;
  logic   eq_q, accept, taken, writes_reg, in_branch;
  logic   instr_req_d, reg_write_d, halted_d;
  logic [DATA_WIDTH-1:0] imm_i, imm_b;

  imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
    .instr(instr),
    .imm_i(imm_i),
    .imm_b(imm_b)
  );

  assign ins_in     = classify(instr[6:0], instr[14:12], instr[31:25]);
  assign in_branch  = (ins_in == INS_BEQ) || (ins_in == INS_BNE);
  assign accept     = (state == FETCH) && instr_valid;
  assign writes_reg = (ins_q == INS_ADD) || (ins_q == INS_ADDI);
  assign taken      = ((ins_q == INS_BEQ) && eq_q) || ((ins_q == INS_BNE) && !eq_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= PC_RESET;
      instr_req <= 1'b0;
      RegWrite  <= 1'b0;
      halted    <= 1'b0;
      ALUctrl   <= 1'b0;
      ALUsrc    <= 1'b0;
      ImmOp     <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      ins_q     <= INS_ILL;
      eq_q      <= 1'b0;
    end else begin
      state     <= next_state;
      instr_req <= instr_req_d;
      RegWrite  <= reg_write_d;
      halted    <= halted_d;
      // Decode fields are captured on the accepting edge so they are valid throughout DECODE.
      if (accept) begin
        ins_q   <= ins_in;
        rs1     <= ADDR_WIDTH'(instr[19:15]);
        rs2     <= ADDR_WIDTH'(instr[24:20]);
        rd      <= ADDR_WIDTH'(instr[11:7]);
        ImmOp   <= in_branch ? imm_b : imm_i;
        ALUsrc  <= (ins_in == INS_ADDI);
        ALUctrl <= in_branch ? ALU_CMP : ALU_ADD;
      end
      if (state == EXECUTE) eq_q <= EQ;
      if (state == WRITEBACK) pc <= taken ? pc + ImmOp : pc + DATA_WIDTH'(4);
    end
  end

  // NOTE: each combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      next_state = FETCH;
      FETCH:     next_state = instr_valid ? DECODE : FETCH;
      DECODE:    next_state = (ins_q == INS_ILL) ? HALT : EXECUTE;
      EXECUTE:   next_state = WRITEBACK;
      WRITEBACK: next_state = FETCH;
      HALT:      next_state = HALT;
      default:   next_state = IDLE;
    endcase
  end

  // Outputs are derived from the state being entered, then registered above.
  always_comb begin
    instr_req_d = 1'b0;
    reg_write_d = 1'b0;
    halted_d    = 1'b0;
    if (next_state == FETCH)                   instr_req_d = 1'b1;
    if (next_state == WRITEBACK && writes_reg) reg_write_d = 1'b1;
    if (next_state == HALT)                    halted_d    = 1'b1;
  end

`ifdef CPU_CTRL_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     retired <= '0;
    else if (state == WRITEBACK) retired <= retired + DATA_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: a driver serves fetches from a directed vector list
// and queues expected decode/writeback results; a monitor checks them as the DUT presents them.
module tb_cpu_ctrl_fsm;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_req;
  logic [DW-1:0] pc;
  logic [31:0]   instr = '0;
  logic          instr_valid = 1'b0;
  logic          EQ = 1'b0;
  logic          ALUctrl, ALUsrc;
  logic [DW-1:0] ImmOp;
  logic [AW-1:0] rs1, rs2, rd;
  logic          RegWrite, halted;
`ifdef CPU_CTRL_RETIRE_CNT_EN
  logic [DW-1:0] retired;
`endif

  cpu_ctrl_fsm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PC_RESET('0)) dut (
    .clk(clk), .rst(rst), .instr_req(instr_req), .pc(pc), .instr(instr),
    .instr_valid(instr_valid), .EQ(EQ), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmOp(ImmOp),
    .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite(RegWrite), .halted(halted)
`ifdef CPU_CTRL_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          delay;
    logic        eq;
    logic        illegal;
    logic [4:0]  rd, rs1, rs2;
    logic        alusrc, aluctrl, imm_chk;
    logic [31:0] imm;
    logic        regwrite;
    logic [31:0] pc, next_pc;
  } vec_t;

  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input int delay, input logic eq,
                              input logic ill, input logic [4:0] d, s1, s2,
                              input logic asrc, actl, ichk, input logic [31:0] imm,
                              input logic rw, input logic [31:0] p, np);
    vec_t v;
    v.instr = ins; v.delay = delay; v.eq = eq; v.illegal = ill;
    v.rd = d; v.rs1 = s1; v.rs2 = s2; v.alusrc = asrc; v.aluctrl = actl; v.imm_chk = ichk;
    v.imm = imm; v.regwrite = rw; v.pc = p; v.next_pc = np;
    return v;
  endfunction

  // Serve one fetch; optionally queue its expectation and drive junk strobes after accept.
  task automatic issue(input vec_t v, input bit push, input bit junk);
    int n;
    n = 0;
    while (instr_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", 32'(instr_req), 32'd1);
    check("fetch_pc", pc, v.pc);
    EQ = v.eq;
    for (int i = 0; i < v.delay; i++) begin
      @(negedge clk);
      check("req_hold", 32'(instr_req), 32'd1);
    end
    instr       = v.instr;
    instr_valid = 1'b1;
    if (push) exp_q.push_back(v);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = '0;
    if (junk) begin
      instr       = 32'hFFFF_FFFF;
      instr_valid = 1'b1;
      repeat (2) @(negedge clk);
      instr_valid = 1'b0;
      instr       = '0;
    end
  endtask

  initial begin : monitor
    vec_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && prev_req && !instr_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: DUT decoded an instruction with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          check("rw_decode", 32'(RegWrite), 32'd0);
          if (!e.illegal) begin
            check("rd", 32'(rd), 32'(e.rd));
            check("rs1", 32'(rs1), 32'(e.rs1));
            check("rs2", 32'(rs2), 32'(e.rs2));
            check("ALUsrc", 32'(ALUsrc), 32'(e.alusrc));
            check("ALUctrl", 32'(ALUctrl), 32'(e.aluctrl));
            if (e.imm_chk) check("ImmOp", ImmOp, e.imm);
          end
          @(negedge clk);
          check("halted", 32'(halted), 32'(e.illegal));
          if (e.illegal) begin
            check("req_halt", 32'(instr_req), 32'd0);
          end else begin
            check("rw_exec", 32'(RegWrite), 32'd0);
            @(negedge clk);
            check("rw_wb", 32'(RegWrite), 32'(e.regwrite));
            @(negedge clk);
            check("rw_after", 32'(RegWrite), 32'd0);
            check("next_pc", pc, e.next_pc);
          end
        end
      end
      prev_req = instr_req;
    end
  end

  initial begin
    vec_t prog[$];
    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_req", 32'(instr_req), 32'd0);
    check("rst_rw", 32'(RegWrite), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_imm", ImmOp, 32'h0);
    rst = 1'b0;
    check("idle_req", 32'(instr_req), 32'd0);
    @(negedge clk);
    check("req_after_rst", 32'(instr_req), 32'd1);
    mon_en = 1'b1;

    //            instr         dly eq ill rd  rs1 rs2 src ctl ichk imm           rw  pc            next_pc
    prog.push_back(mk(32'h00500093, 0, 0, 0, 1,  0,  5,  1, 0, 1, 32'h0000_0005, 1, 32'h0,        32'h4));
    prog.push_back(mk(32'h002081B3, 3, 0, 0, 3,  1,  2,  0, 0, 0, 32'h0,         1, 32'h4,        32'h8));
    prog.push_back(mk(32'hFFF30293, 0, 0, 0, 5,  6,  31, 1, 0, 1, 32'hFFFF_FFFF, 1, 32'h8,        32'hC));
    prog.push_back(mk(32'h7FF00393, 1, 0, 0, 7,  0,  31, 1, 0, 1, 32'h0000_07FF, 1, 32'hC,        32'h10));
    prog.push_back(mk(32'hFE209CE3, 0, 0, 0, 25, 1,  2,  0, 1, 1, 32'hFFFF_FFF8, 0, 32'h10,       32'h8));
    prog.push_back(mk(32'h00000463, 0, 1, 0, 8,  0,  0,  0, 1, 1, 32'h0000_0008, 0, 32'h8,        32'h10));
    prog.push_back(mk(32'hFE209CE3, 0, 1, 0, 25, 1,  2,  0, 1, 1, 32'hFFFF_FFF8, 0, 32'h10,       32'h14));
    prog.push_back(mk(32'h00000463, 0, 0, 0, 8,  0,  0,  0, 1, 1, 32'h0000_0008, 0, 32'h14,       32'h18));
    prog.push_back(mk(32'hFE0002E3, 0, 1, 0, 5,  0,  0,  0, 1, 1, 32'hFFFF_FFE4, 0, 32'h18,       32'hFFFF_FFFC));
    prog.push_back(mk(32'h00000463, 2, 1, 0, 8,  0,  0,  0, 1, 1, 32'h0000_0008, 0, 32'hFFFF_FFFC, 32'h4));
    prog.push_back(mk(32'hFFFFFFFF, 0, 0, 1, 0,  0,  0,  0, 0, 0, 32'h0,         0, 32'h4,        32'h4));
    foreach (prog[i]) issue(prog[i], 1'b1, (i == 1));

    // Halted: no requests, pc frozen, sticky flag.
    repeat (10) @(negedge clk);
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_req", 32'(instr_req), 32'd0);
    check("halt_pc", pc, 32'h4);
    check("halt_rw", 32'(RegWrite), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
`ifdef CPU_CTRL_RETIRE_CNT_EN
    check("retired", retired, 32'd10);
`endif

    // Reset clears the halt.
    rst = 1'b1;
    @(negedge clk);
    check("unhalt", 32'(halted), 32'd0);
    check("unhalt_pc", pc, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("req_after_unhalt", 32'(instr_req), 32'd1);
    issue(mk(32'h00500093, 0, 0, 0, 1, 0, 5, 1, 0, 1, 32'h5, 1, 32'h0, 32'h4), 1'b1, 1'b0);

    // Reset in the middle of EXECUTE aborts the instruction with no write.
    mon_en = 1'b0;
    issue(mk(32'h002081B3, 0, 0, 0, 3, 1, 2, 0, 0, 0, 32'h0, 1, 32'h4, 32'h8), 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_pc", pc, 32'h0);
    check("abort_rw", 32'(RegWrite), 32'd0);
    check("abort_req", 32'(instr_req), 32'd0);
`ifdef CPU_CTRL_RETIRE_CNT_EN
    check("abort_retired", retired, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_rw_after", 32'(RegWrite), 32'd0);
    check("req_after_abort", 32'(instr_req), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
